// File: rtl/shift_cmd_gen_if.sv
// Handshake and command bundle between the lab control logic and shift_cmd_gen.
// The master side requests moves; the slave side is the sequencer itself.
interface shift_cmd_gen_if #(
    parameter int WIDTH = 4
) ();
    localparam int PW = $clog2(WIDTH);

    logic             start;
    logic [PW-1:0]    target;
    logic             abort;
    logic             ready;
    logic             busy;
    logic             done;
    logic             shift_left;
    logic             shift_right;
    logic [PW-1:0]    pos;
    logic [WIDTH-1:0] pattern;

    modport master (
        output start, target, abort,
        input  ready, busy, done, shift_left, shift_right, pos, pattern
    );

    modport slave (
        input  start, target, abort,
        output ready, busy, done, shift_left, shift_right, pos, pattern
    );
endinterface

// File: rtl/shift_cmd_gen.sv
// Issues single-cycle shift_left/shift_right pulses to walk a one-hot shifter to a
// requested position by the shortest route, tracking the shifter position locally.
module shift_cmd_gen #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    shift_cmd_gen_if.slave bus
);
    localparam int PW = $clog2(WIDTH);
    localparam int CW = $clog2(SETTLE_CYCLES + 2);
    localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE,
        DONE
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] pos, pos_next;
    logic [PW-1:0] steps, steps_next;
    logic          dir_left, dir_left_next;
    logic [CW-1:0] settle_cnt, settle_cnt_next;
    logic [PW-1:0] dist_left, dist_right;

    // Both distances wrap naturally in PW bits; a tie is resolved towards left.
    assign dist_left  = bus.target - pos;
    assign dist_right = pos - bus.target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pos        <= '0;
            steps      <= '0;
            dir_left   <= 1'b1;
            settle_cnt <= '0;
        end else begin
            state      <= state_next;
            pos        <= pos_next;
            steps      <= steps_next;
            dir_left   <= dir_left_next;
            settle_cnt <= settle_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        pos_next        = pos;
        steps_next      = steps;
        dir_left_next   = dir_left;
        settle_cnt_next = settle_cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (dist_left == '0) begin
                        state_next = DONE;
                    end else begin
                        dir_left_next = (dist_left <= dist_right);
                        steps_next    = (dist_left <= dist_right) ? dist_left : dist_right;
                        state_next    = STEP;
                    end
                end
            end
            STEP: begin
                // The pulse is already on the wire, so pos follows it even when aborting.
                pos_next   = dir_left ? pos + PW'(1) : pos - PW'(1);
                steps_next = steps - PW'(1);
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (SETTLE_CYCLES > 0) begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                end else if (steps != PW'(1)) begin
                    state_next = STEP;
                end else begin
                    state_next = DONE;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = (steps != '0) ? STEP : DONE;
                end else begin
                    settle_cnt_next = settle_cnt + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready       = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.shift_left  = (state == STEP) && dir_left;
    assign bus.shift_right = (state == STEP) && !dir_left;
    assign bus.pos         = pos;
    assign bus.pattern     = {{(WIDTH-1){1'b0}}, 1'b1} << pos;
endmodule

// File: tb/tb_shift_cmd_gen.sv
// Self-checking bench for shift_cmd_gen: one instance with SETTLE_CYCLES=2 and one with 0,
// both compared cycle by cycle against a schedule derived from shortest-path arithmetic.
module tb_shift_cmd_gen;
    localparam int WIDTH = 4;
    localparam int PW    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    shift_cmd_gen_if #(.WIDTH(WIDTH)) bus_a ();
    shift_cmd_gen_if #(.WIDTH(WIDTH)) bus_b ();

    shift_cmd_gen #(.WIDTH(WIDTH), .SETTLE_CYCLES(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    shift_cmd_gen #(.WIDTH(WIDTH), .SETTLE_CYCLES(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct packed {
        logic             ready;
        logic             busy;
        logic             done;
        logic             sl;
        logic             sr;
        logic [PW-1:0]    pos;
        logic [WIDTH-1:0] pattern;
    } obs_t;

    int tests_run    = 0;
    int tests_failed = 0;
    int model_pos[2];
    int settle[2];

    task automatic sample(input int sel, output obs_t o);
        if (sel == 0)
            o = {bus_a.ready, bus_a.busy, bus_a.done, bus_a.shift_left, bus_a.shift_right,
                 bus_a.pos, bus_a.pattern};
        else
            o = {bus_b.ready, bus_b.busy, bus_b.done, bus_b.shift_left, bus_b.shift_right,
                 bus_b.pos, bus_b.pattern};
    endtask

    task automatic drive(input int sel, input logic s, input logic [PW-1:0] t, input logic ab);
        if (sel == 0) begin
            bus_a.start = s; bus_a.target = t; bus_a.abort = ab;
        end else begin
            bus_b.start = s; bus_b.target = t; bus_b.abort = ab;
        end
    endtask

    // Idle-state expectations: position from the model, no pulses, ready high.
    task automatic check_idle(input int sel, input string name);
        obs_t             o;
        logic [PW-1:0]    ep;
        logic [WIDTH-1:0] epat;
        sample(sel, o);
        ep = model_pos[sel][PW-1:0];
        epat = '0;
        epat[ep] = 1'b1;
        tests_run++;
        if ({o.ready, o.busy, o.done, o.sl, o.sr} !== 5'b10000) begin
            tests_failed++;
            $display("[TB] FAIL %s status sel=%0d got=%b expected=%b", name, sel,
                     {o.ready, o.busy, o.done, o.sl, o.sr}, 5'b10000);
        end
        tests_run++;
        if ({o.pos, o.pattern} !== {ep, epat}) begin
            tests_failed++;
            $display("[TB] FAIL %s position sel=%0d got pos=%0d pattern=%b expected pos=%0d pattern=%b",
                     name, sel, o.pos, o.pattern, ep, epat);
        end
    endtask

    // Runs one move from IDLE (entered and left at a negedge with the DUT idle).
    // abort_at: 0 = no abort, -1 = random abort cycle if the move has steps, >0 = that cycle.
    task automatic test_move(input int sel, input int tgt, input int abort_req);
        obs_t             o;
        int               s, dl, dr, n, sign, done_c, last_c, abort_at, pb, epos;
        logic             left, exp_pulse;
        logic [PW-1:0]    ep;
        logic [WIDTH-1:0] epat;
        s      = settle[sel];
        dl     = (tgt - model_pos[sel] + WIDTH) % WIDTH;
        dr     = (model_pos[sel] - tgt + WIDTH) % WIDTH;
        left   = (dl <= dr);
        n      = left ? dl : dr;
        sign   = left ? 1 : -1;
        done_c = 1 + n * (s + 1);
        abort_at = abort_req;
        if (abort_req < 0) abort_at = (n > 0) ? $urandom_range(1, done_c - 1) : 0;
        last_c = (abort_at > 0) ? abort_at : done_c;

        drive(sel, 1'b1, tgt[PW-1:0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        for (int c = 1; c <= last_c; c++) begin
            sample(sel, o);
            exp_pulse = (n > 0) && ((c - 1) % (s + 1) == 0) && ((c - 1) / (s + 1) < n);
            pb   = (c - 1 + s) / (s + 1);
            if (pb > n) pb = n;
            epos = ((model_pos[sel] + sign * pb) % WIDTH + WIDTH) % WIDTH;
            ep   = epos[PW-1:0];
            epat = '0;
            epat[ep] = 1'b1;
            tests_run++;
            if ({o.sl, o.sr} !== {exp_pulse && left, exp_pulse && !left}) begin
                tests_failed++;
                $display("[TB] FAIL pulses sel=%0d tgt=%0d cycle=%0d got=%b expected=%b", sel, tgt, c,
                         {o.sl, o.sr}, {exp_pulse && left, exp_pulse && !left});
            end
            tests_run++;
            if ({o.ready, o.busy, o.done} !== {1'b0, 1'b1, c == done_c}) begin
                tests_failed++;
                $display("[TB] FAIL status sel=%0d tgt=%0d cycle=%0d got=%b expected=%b", sel, tgt, c,
                         {o.ready, o.busy, o.done}, {1'b0, 1'b1, c == done_c});
            end
            tests_run++;
            if ({o.pos, o.pattern} !== {ep, epat}) begin
                tests_failed++;
                $display("[TB] FAIL position sel=%0d tgt=%0d cycle=%0d got pos=%0d pattern=%b expected pos=%0d pattern=%b",
                         sel, tgt, c, o.pos, o.pattern, ep, epat);
            end
            // Outside IDLE, start and target are noise that must be ignored.
            if (c == abort_at) drive(sel, 1'b1, PW'($urandom), 1'b1);
            else drive(sel, 1'(($urandom % 2)), PW'($urandom), 1'b0);
            @(negedge clk);
        end

        pb = (last_c + s) / (s + 1);
        if (pb > n) pb = n;
        model_pos[sel] = ((model_pos[sel] + sign * pb) % WIDTH + WIDTH) % WIDTH;
        drive(sel, 1'b0, '0, 1'b0);
        check_idle(sel, (abort_at > 0) ? "abort_idle" : "after_done");
        if (abort_at > 0) begin
            repeat (2) begin
                @(negedge clk);
                check_idle(sel, "abort_no_done");
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        model_pos[0] = 0;
        model_pos[1] = 0;
        repeat (2) @(negedge clk);
        check_idle(0, "in_reset");
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_idle(0, "reset_idle");
            check_idle(1, "reset_idle");
        end
    endtask

    task automatic test_directed();
        test_move(0, 1, 0);
        test_move(0, 0, 0);
        test_move(0, 3, 0);
        test_move(0, 0, 0);
        test_move(0, 2, 0);
        test_move(0, 2, 0);
        test_move(0, 0, 0);
    endtask

    task automatic test_abort();
        test_move(0, 2, 2);
        test_move(1, 2, 1);
    endtask

    task automatic test_async_reset();
        obs_t o;
        int   tgt;
        // Reset during SETTLE.
        tgt = (model_pos[0] + 1) % WIDTH;
        drive(0, 1'b1, tgt[PW-1:0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_pos[0] = 0;
        model_pos[1] = 0;
        check_idle(0, "async_reset_settle");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // Reset while a pulse is on the wire.
        drive(0, 1'b1, 2'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, '0, 1'b0);
        sample(0, o);
        tests_run++;
        if ({o.sl, o.sr} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL pulse_before_reset got=%b expected=%b", {o.sl, o.sr}, 2'b10);
        end
        #1 rst = 1'b1;
        #1;
        check_idle(0, "async_reset_pulse");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) test_move(1, (model_pos[1] + 2) % WIDTH, 0);
        test_move(1, 1, 0);
        test_move(1, 1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            test_move(i % 2, $urandom_range(0, WIDTH - 1), (($urandom % 4) == 0) ? -1 : 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        settle[0] = 2;
        settle[1] = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
